// File: rtl/fifo_led_pacer.sv
// ---------------------------------------------------------------------------
// fifo_led_pacer
//
// Purpose:
//   Drains a FIFO onto the board LEDs at human speed. Every edge (rising or
//   falling) of the slow divider toggle tick_in is one display step. On a
//   step the pacer pops one word, waits RD_LATENCY clk cycles for the read
//   data, latches it onto led and keeps it there for HOLD_TICKS steps. The
//   step that ends a hold immediately pops the next word if one is
//   available. A step that finds the FIFO empty is an underrun.
//
// Parameters:
//   DATA_W      width of FIFO data and LED bus
//   RD_LATENCY  clk cycles from fifo_rd_en high to valid fifo_dout (1..4)
//   HOLD_TICKS  display steps each word stays on led (1..255)
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   tick_in       slow toggle from the clock divider (clk-synchronous)
//   fifo_empty    FIFO empty flag
//   fifo_dout     FIFO read data
//   fifo_rd_en    FIFO pop strobe, one clk cycle per word
//   led           currently displayed word
//   busy          high whenever the FSM is not idle
//   underrun_cnt  saturating count of steps that found the FIFO empty
//
// Build option:
//   UNDERRUN_CNT_EN  when defined, underrun_cnt is a live saturating
//                    counter; otherwise it is tied to zero.
//
// State table:
//   IDLE | waiting for a step; led shows the last word (or 0 after reset)
//   RD   | fifo_rd_en high for this single cycle
//   WAIT | counting down the FIFO read latency, then latch fifo_dout
//   SHOW | word on led; each step burns one hold count
// ---------------------------------------------------------------------------
module fifo_led_pacer #(
    parameter int DATA_W     = 4,
    parameter int RD_LATENCY = 1,
    parameter int HOLD_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic [7:0]        underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        SHOW = 2'd3
    } state_t;

    localparam logic [1:0] LAT_INIT  = 2'(RD_LATENCY - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

    state_t      state;
    state_t      state_nx;
    logic        rd_en_nx;
    logic        busy_nx;
    logic        tick_q;
    logic        step;
    logic        hold_last;
    logic        data_ready;
    logic [1:0]  lat_cnt;
    logic [7:0]  hold_cnt;

    // tick_q follows tick_in even during reset so releasing reset never
    // produces a phantom step.
    always_ff @(posedge clk) begin
        tick_q <= tick_in;
    end

    assign step       = tick_in ^ tick_q;
    // The step that would take hold_cnt to zero ends the hold. The <= guards
    // against a zero count ever stalling the FSM in SHOW.
    assign hold_last  = (hold_cnt <= 8'd1);
    assign data_ready = (lat_cnt == 2'd0);

    // ------------------------------------------------------------------
    // State register (outputs are registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            fifo_rd_en <= rd_en_nx;
            busy       <= busy_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (step && !fifo_empty) begin
                    state_nx = RD;
                end
            end
            RD: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (data_ready) begin
                    state_nx = SHOW;
                end
            end
            SHOW: begin
                if (step && hold_last) begin
                    state_nx = fifo_empty ? IDLE : RD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the next state so the registered
    // outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        rd_en_nx = (state_nx == RD);
        busy_nx  = (state_nx != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: latency timer, hold timer, LED register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 2'd0;
        end else if (state == RD) begin
            lat_cnt <= LAT_INIT;
        end else if (state == WAIT && !data_ready) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == WAIT && data_ready) begin
            hold_cnt <= HOLD_INIT;
        end else if (state == SHOW && step && hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    // A word popped just before a reset is dropped: reset forces IDLE, so
    // the WAIT-state capture below never happens for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else if (state == WAIT && data_ready) begin
            led <= fifo_dout;
        end
    end

    // ------------------------------------------------------------------
    // Underrun counter
    // ------------------------------------------------------------------
`ifdef UNDERRUN_CNT_EN
    logic underrun_step;

    // Same conditions the FSM uses to decide between popping and idling;
    // steps landing in RD or WAIT are deliberately not counted.
    assign underrun_step = step && fifo_empty &&
                           ((state == IDLE) || (state == SHOW && hold_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= 8'd0;
        end else if (underrun_step && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`else
    assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_led_pacer.sv
// Bench for fifo_led_pacer. Two instances share clk/rst/tick_in: dut0 with
// HOLD_TICKS=1 and dut1 with HOLD_TICKS=3, each fed by its own FIFO model
// with one cycle of read latency. Words are pushed into a per-DUT expected
// queue when loaded into the FIFO and popped when the LED update appears.
module tb_fifo_led_pacer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b1;

    logic       empty0, empty1;
    logic [3:0] dout0 = 4'h0, dout1 = 4'h0;
    logic       rd_en0, rd_en1;
    logic [3:0] led0, led1;
    logic       busy0, busy1;
    logic [7:0] urun0, urun1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [3:0] mem0 [0:15];
    logic [3:0] mem1 [0:15];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic [3:0] exp0 [$];
    logic [3:0] exp1 [$];

    int pend0 = 0, pend1 = 0;
    int pulses0 = 0, pulses1 = 0;
    int width0 = 0, width1 = 0;
    int last_rd1 = 0, gap1 = 0;

    fifo_led_pacer #(.DATA_W(4), .RD_LATENCY(1), .HOLD_TICKS(1)) dut0 (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .fifo_empty(empty0), .fifo_dout(dout0), .fifo_rd_en(rd_en0),
        .led(led0), .busy(busy0), .underrun_cnt(urun0)
    );

    fifo_led_pacer #(.DATA_W(4), .RD_LATENCY(1), .HOLD_TICKS(3)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .fifo_empty(empty1), .fifo_dout(dout1), .fifo_rd_en(rd_en1),
        .led(led1), .busy(busy1), .underrun_cnt(urun1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: registered read, one cycle latency
    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);

    always @(posedge clk) begin
        if (rd_en0) begin
            dout0 <= mem0[rp0 % 16];
            rp0   <= rp0 + 1;
        end
        if (rd_en1) begin
            dout1 <= mem1[rp1 % 16];
            rp1   <= rp1 + 1;
        end
    end

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push0(input logic [3:0] v);
        mem0[wp0 % 16] = v;
        wp0++;
        exp0.push_back(v);
    endtask

    task automatic push1(input logic [3:0] v);
        mem1[wp1 % 16] = v;
        wp1++;
        exp1.push_back(v);
    endtask

    task automatic do_step();
        @(negedge clk);
        tick_in = ~tick_in;
        repeat (9) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: sampled 1 time unit after each rising edge. rd_en seen in
    // cycle N means led must carry the word from cycle N+2 on.
    initial begin
        logic [3:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (pend0 > 0) begin
                if (rst) begin
                    if (exp0.size() > 0) w = exp0.pop_front();
                    pend0 = 0;
                end else begin
                    pend0--;
                    if (pend0 == 0) begin
                        if (exp0.size() == 0) check("sb0_underflow", 0, 1);
                        else begin
                            w = exp0.pop_front();
                            check("led0_word", led0, w);
                        end
                    end
                end
            end
            if (pend1 > 0) begin
                if (rst) begin
                    if (exp1.size() > 0) w = exp1.pop_front();
                    pend1 = 0;
                end else begin
                    pend1--;
                    if (pend1 == 0) begin
                        if (exp1.size() == 0) check("sb1_underflow", 0, 1);
                        else begin
                            w = exp1.pop_front();
                            check("led1_word", led1, w);
                        end
                    end
                end
            end
            if (rd_en0) begin
                if (width0 == 0) begin
                    pulses0++;
                    pend0 = 2;
                end
                width0++;
            end else if (width0 != 0) begin
                check("rd_en0_width", width0, 1);
                width0 = 0;
            end
            if (rd_en1) begin
                if (width1 == 0) begin
                    pulses1++;
                    pend1 = 2;
                    gap1 = cyc - last_rd1;
                    last_rd1 = cyc;
                end
                width1++;
            end else if (width1 != 0) begin
                check("rd_en1_width", width1, 1);
                width1 = 0;
            end
        end
    end

    initial begin
        int p0;
        int p1;
        int seen;
        int exp_u3;
        int exp_usat;
`ifdef UNDERRUN_CNT_EN
        exp_u3   = 3;
        exp_usat = 255;
`else
        exp_u3   = 0;
        exp_usat = 0;
`endif

        // Reset with tick_in high, release, nothing happens for 20 clk
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_pulses0", pulses0, 0);
        check("idle_pulses1", pulses1, 0);
        check("idle_led0", led0, 0);
        check("idle_busy0", busy0, 0);
        check("idle_busy1", busy1, 0);
        check("idle_urun0", urun0, 0);

        // Single word: cycle-exact rd_en / led timing
        push0(4'hA);
        @(negedge clk);
        tick_in = ~tick_in;
        check("single_rd_step", rd_en0, 0);
        @(negedge clk);
        check("single_rd_s1", rd_en0, 1);
        check("single_busy_s1", busy0, 1);
        @(negedge clk);
        check("single_rd_s2", rd_en0, 0);
        @(negedge clk);
        check("single_led", led0, 4'hA);
        repeat (6) @(negedge clk);
        check("single_busy_show", busy0, 1);
        do_step();
        check("single_busy_end", busy0, 0);
        check("single_led_hold", led0, 4'hA);

        // Three words back-to-back, then an empty step
        p0 = pulses0;
        push0(4'hA);
        push0(4'h5);
        push0(4'hC);
        repeat (3) do_step();
        check("seq_pulses", pulses0 - p0, 3);
        check("seq_busy_show", busy0, 1);
        do_step();
        check("seq_led_last", led0, 4'hC);
        check("seq_busy_idle", busy0, 0);

        // Underruns from a clean reset
        do_reset();
        p0 = pulses0;
        p1 = pulses1;
        repeat (3) do_step();
        check("urun0_3", urun0, exp_u3);
        check("urun1_3", urun1, exp_u3);
        check("urun_pulses0", pulses0 - p0, 0);
        check("urun_pulses1", pulses1 - p1, 0);
        check("urun_led0", led0, 0);
        repeat (297) do_step();
        check("urun0_sat", urun0, exp_usat);
        check("urun1_sat", urun1, exp_usat);

        // HOLD_TICKS=3 instance
        do_reset();
        p1 = pulses1;
        push1(4'h1);
        push1(4'h2);
        do_step();
        check("h3_led_s1", led1, 1);
        do_step();
        check("h3_led_s2", led1, 1);
        do_step();
        check("h3_led_s3", led1, 1);
        check("h3_pulses_s3", pulses1 - p1, 1);
        do_step();
        check("h3_led_s4", led1, 2);
        check("h3_pulses_s4", pulses1 - p1, 2);
        check("h3_gap", gap1, 30);

        // Reset one cycle after rd_en: word dropped, led cleared
        do_reset();
        push0(4'h7);
        push0(4'h9);
        @(negedge clk);
        tick_in = ~tick_in;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (rd_en0) seen = 1;
        end
        check("rst_mid_rd_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rd_en", rd_en0, 0);
        check("rst_mid_led", led0, 0);
        check("rst_mid_busy", busy0, 0);
        repeat (10) @(negedge clk);
        check("rst_mid_led_stay", led0, 0);
        do_step();
        check("rst_mid_next", led0, 4'h9);

        repeat (5) @(negedge clk);
        check("sb0_left", exp0.size(), 0);
        check("sb1_left", exp1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
